// File: rtl/falafel_lsu_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one falafel LSU. It runs one request
// at a time and keeps a single memory lock that only its owner can pass while it is held.
package falafel_lsu_pkg;
  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_STORE  = 2'd1,
    OP_LOCK   = 2'd2,
    OP_UNLOCK = 2'd3
  } op_e;

  typedef struct packed {
    logic        val;
    op_e         op;
    logic [15:0] addr;
    logic [31:0] wdata;
  } header_req_t;

  typedef struct packed {
    logic        val;
    logic        err;
    logic [31:0] rdata;
  } header_rsp_t;
endpackage

module falafel_lsu_arbiter
  import falafel_lsu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  header_req_t [N_REQ-1:0] req_header_i,
  output logic        [N_REQ-1:0] req_rdy_o,
  output header_rsp_t [N_REQ-1:0] rsp_header_o,
  input  logic        [N_REQ-1:0] rsp_rdy_i,
  output header_req_t             lsu_req_header_o,
  input  logic                    lsu_ready_i,
  input  header_rsp_t             lsu_rsp_header_i,
  output logic                    lsu_rsp_rdy_o,
  output logic                    lock_held_o,
  output logic        [IDX_W-1:0] lock_owner_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP
  } state_e;

  state_e            r_state;
  logic [IDX_W-1:0]  r_last_grant;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  r_lock_owner;
  logic              r_lock_held;
  header_req_t       r_hdr;

  logic [N_REQ-1:0]  w_elig;
  logic              w_found;
  logic [IDX_W-1:0]  w_winner;
  logic              w_rsp_hs;

  // While the lock is held only its owner may be granted; everyone else waits.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = req_header_i[i].val && (!r_lock_held || (IDX_W'(i) == r_lock_owner));
    end
  end

  always_comb begin : rr_pick
    int v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      v_idx = (int'(r_last_grant) + k) % N_REQ;
      if (!w_found && w_elig[v_idx]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(v_idx);
      end
    end
  end

  assign w_rsp_hs = (r_state == S_WAIT_RSP) && lsu_rsp_header_i.val && rsp_rdy_i[r_grant];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_grant      <= '0;
      r_hdr        <= '0;
      r_lock_held  <= 1'b0;
      r_lock_owner <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_hdr   <= req_header_i[w_winner];
            r_grant <= w_winner;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (lsu_ready_i) r_state <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (w_rsp_hs) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
            if (r_hdr.op == OP_LOCK) begin
              r_lock_held  <= 1'b1;
              r_lock_owner <= r_grant;
            end else if (r_hdr.op == OP_UNLOCK) begin
              r_lock_held  <= 1'b0;
              r_lock_owner <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while rst_i is high, even before the reset edge lands.
  always_comb begin
    req_rdy_o = '0;
    if (!rst_i && (r_state == S_IDLE) && w_found) req_rdy_o[w_winner] = 1'b1;

    lsu_req_header_o     = r_hdr;
    lsu_req_header_o.val = !rst_i && (r_state == S_ISSUE);

    rsp_header_o  = '0;
    lsu_rsp_rdy_o = 1'b0;
    if (!rst_i && (r_state == S_WAIT_RSP)) begin
      rsp_header_o[r_grant] = lsu_rsp_header_i;
      lsu_rsp_rdy_o         = rsp_rdy_i[r_grant];
    end
  end

  assign lock_held_o  = r_lock_held && !rst_i;
  assign lock_owner_o = lock_held_o ? r_lock_owner : '0;

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Scoreboard bench for falafel_lsu_arbiter (N_REQ=4): a transaction-level model predicts grants,
// LSU requests, routed responses and lock status; a monitor pops and compares them.
module tb_falafel_lsu_arbiter;
  import falafel_lsu_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  header_req_t [N-1:0] req_header;
  logic [N-1:0]      req_rdy;
  header_rsp_t [N-1:0] rsp_header;
  logic [N-1:0]      rsp_rdy;
  header_req_t       lsu_req;
  logic              lsu_ready;
  header_rsp_t       lsu_rsp;
  logic              lsu_rsp_rdy;
  logic              lock_held;
  logic [1:0]        lock_owner;

  falafel_lsu_arbiter #(.N_REQ(N)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_header_i     (req_header),
    .req_rdy_o        (req_rdy),
    .rsp_header_o     (rsp_header),
    .rsp_rdy_i        (rsp_rdy),
    .lsu_req_header_o (lsu_req),
    .lsu_ready_i      (lsu_ready),
    .lsu_rsp_header_i (lsu_rsp),
    .lsu_rsp_rdy_o    (lsu_rsp_rdy),
    .lock_held_o      (lock_held),
    .lock_owner_o     (lock_owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = free, 1 = handing request to LSU, 2 = awaiting LSU answer.
  int          m_phase, m_last, m_grant, m_owner;
  bit          m_held;
  header_req_t m_hdr;
  logic [N-1:0] acc;
  int          scyc = 0;

  typedef struct { int idx; header_rsp_t h; } rsp_exp_t;
  typedef struct { bit held; int owner; bit rsp_rdy; } ctl_t;
  int          q_grant[$];
  header_req_t q_lsu[$];
  rsp_exp_t    q_rsp[$];
  ctl_t        q_ctl[$];

  // Monitor-side observation log and counters.
  int obs_g[$];
  int obs_t[$];
  int lsu_val_cnt, lrr_cnt;
  int rsp_cnt[N];

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (req_header[i].val && (!m_held || i == m_owner)) return i;
    end
    return -1;
  endfunction

  task automatic step();
    ctl_t c;
    rsp_exp_t r;
    int w;
    scyc++;
    acc = '0;
    c.held    = !rst && m_held;
    c.owner   = c.held ? m_owner : 0;
    c.rsp_rdy = 1'b0;
    if (rst) begin
      m_phase = 0; m_last = N - 1; m_grant = 0; m_held = 0; m_owner = 0; m_hdr = '0;
    end else begin
      case (m_phase)
        0: begin
          w = pick();
          if (w >= 0) begin
            q_grant.push_back(w);
            m_hdr = req_header[w]; m_grant = w; m_phase = 1; acc[w] = 1'b1;
          end
        end
        1: begin
          q_lsu.push_back(m_hdr);
          if (lsu_ready) m_phase = 2;
        end
        default: begin
          c.rsp_rdy = rsp_rdy[m_grant];
          if (lsu_rsp.val) begin
            r.idx = m_grant; r.h = lsu_rsp;
            q_rsp.push_back(r);
            if (rsp_rdy[m_grant]) begin
              m_last = m_grant; m_phase = 0;
              if (m_hdr.op == OP_LOCK) begin m_held = 1; m_owner = m_grant; end
              else if (m_hdr.op == OP_UNLOCK) begin m_held = 0; m_owner = 0; end
            end
          end
        end
      endcase
    end
    q_ctl.push_back(c);
    @(negedge clk);
  endtask

  ctl_t        mc;
  int          mg;
  header_req_t ml;
  rsp_exp_t    mr;
  always @(negedge clk) begin
    #2;
    if (q_ctl.size() > 0) begin
      mc = q_ctl.pop_front();
      chk("lock_held", 64'(lock_held), 64'(mc.held));
      chk("lock_owner", 64'(lock_owner), 64'(mc.owner));
      chk("lsu_rsp_rdy", 64'(lsu_rsp_rdy), 64'(mc.rsp_rdy));
    end
    if (lsu_rsp_rdy) lrr_cnt++;
    if (req_rdy != '0) begin
      chk("rdy_onehot", 64'($onehot(req_rdy)), 64'd1);
      mg = 0;
      for (int i = 0; i < N; i++) if (req_rdy[i]) mg = i;
      obs_g.push_back(mg);
      obs_t.push_back(scyc);
      if (q_grant.size() == 0) chk("grant_unexpected", 64'(req_rdy), 64'd0);
      else chk("grant_idx", 64'(req_rdy), 64'(4'b0001 << q_grant.pop_front()));
    end
    if (lsu_req.val) begin
      lsu_val_cnt++;
      if (q_lsu.size() == 0) chk("lsu_req_unexpected", 64'(lsu_req.val), 64'd0);
      else begin
        ml = q_lsu.pop_front();
        chk("lsu_req_hdr", 64'(lsu_req), 64'(ml));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rsp_header[i].val) begin
        rsp_cnt[i]++;
        if (q_rsp.size() == 0) chk("rsp_unexpected", 64'(i), 64'hFF);
        else begin
          mr = q_rsp.pop_front();
          chk("rsp_idx", 64'(i), 64'(mr.idx));
          chk("rsp_hdr", 64'(rsp_header[i]), 64'(mr.h));
        end
      end
    end
  end

  function automatic header_req_t mk(input op_e op, input bit v);
    header_req_t h;
    h.val = v; h.op = op; h.addr = 16'($urandom); h.wdata = $urandom;
    return h;
  endfunction

  function automatic op_e rand_op();
    int r = $urandom % 100;
    if (r < 40) return OP_LOAD;
    if (r < 70) return OP_STORE;
    if (r < 85) return OP_LOCK;
    return OP_UNLOCK;
  endfunction

  // Accepted requests are replaced (new op if the requester keeps going, else dropped with junk fields).
  task automatic refill(input logic [N-1:0] mask, input op_e op);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        req_header[i] = mk(op, mask[i]);
      end else if (mask[i] && !req_header[i].val) begin
        req_header[i] = mk(op, 1'b1);
      end
    end
  endtask

  task automatic lsu_prep(input int pct, input bit garb);
    lsu_rsp.err   = 1'($urandom);
    lsu_rsp.rdata = $urandom;
    if (!rst && m_phase == 2 && ($urandom % 100) < pct) lsu_rsp.val = 1'b1;
    else lsu_rsp.val = garb && (($urandom % 4) == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) req_header[i] = mk(OP_LOAD, 1'b0);
    lsu_rsp = '0; lsu_ready = 1'b0; rsp_rdy = '0;
    repeat (2) step();
    rst = 1'b0; acc = '0;
  endtask

  task automatic clear_obs();
    obs_g.delete(); obs_t.delete();
  endtask

  int exp_a[4] = '{0, 1, 0, 1};
  int unl_k, rel;
  bit unl_sent, unl_acc;

  initial begin
    rst = 1'b1;
    req_header = '0; rsp_rdy = '0; lsu_ready = 1'b0; lsu_rsp = '0; acc = '0;
    m_phase = 0; m_last = N - 1; m_grant = 0; m_held = 0; m_owner = 0; m_hdr = '0;
    @(negedge clk);
    do_reset();
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_lsu_val", 64'(lsu_req.val), 64'd0);
    chk("rst_lsu_rsp_rdy", 64'(lsu_rsp_rdy), 64'd0);
    chk("rst_lock_held", 64'(lock_held), 64'd0);
    chk("rst_lock_owner", 64'(lock_owner), 64'd0);
    chk("rst_rsp_val", 64'({rsp_header[3].val, rsp_header[2].val, rsp_header[1].val, rsp_header[0].val}), 64'd0);

    // Two continuous LOAD requesters alternate, one grant every three cycles.
    lsu_ready = 1'b1; rsp_rdy = '1; clear_obs();
    repeat (12) begin refill(4'b0011, OP_LOAD); lsu_prep(100, 0); step(); end
    chk("rr_count", 64'(obs_g.size()), 64'd4);
    for (int k = 0; k < 4 && k < obs_g.size(); k++) chk("rr_order", 64'(obs_g[k]), 64'(exp_a[k]));
    for (int k = 1; k < 4 && k < obs_t.size(); k++) chk("rr_spacing", 64'(obs_t[k] - obs_t[k-1]), 64'd3);

    // Requester 1 takes the lock, keeps exclusive access, then unlocks; 0 goes next.
    do_reset();
    lsu_ready = 1'b1; rsp_rdy = '1;
    req_header[1] = mk(OP_LOCK, 1'b1);
    for (int n = 0; n < 20 && !m_held; n++) begin refill(4'b0000, OP_LOAD); lsu_prep(100, 0); step(); end
    chk("lock_held_set", 64'(lock_held), 64'd1);
    chk("lock_owner_set", 64'(lock_owner), 64'd1);
    clear_obs(); unl_sent = 0; unl_acc = 0; unl_k = -1;
    for (int n = 0; n < 60 && !(unl_acc && !m_held && m_phase == 0 && n > 20); n++) begin
      if (acc[1] && unl_sent && !unl_acc) begin unl_acc = 1; unl_k = obs_g.size(); end
      if (n >= 15 && acc[1] && !unl_sent) begin acc[1] = 1'b0; req_header[1] = mk(OP_UNLOCK, 1'b1); unl_sent = 1; end
      refill(unl_sent ? 4'b0001 : 4'b0011, OP_LOAD);
      lsu_prep(100, 0); step();
    end
    repeat (4) begin refill(4'b0001, OP_LOAD); lsu_prep(100, 0); step(); end
    chk("unlock_reached", 64'(unl_k > 5), 64'd1);
    for (int k = 0; k < unl_k && k < obs_g.size(); k++) chk("locked_grant", 64'(obs_g[k]), 64'd1);
    chk("after_unlock_grant", 64'((unl_k >= 0 && unl_k < obs_g.size()) ? obs_g[unl_k] : -1), 64'd0);
    chk("lock_released", 64'(lock_held), 64'd0);

    // LSU stalls the request for five cycles.
    do_reset();
    rsp_rdy = '1; req_header[0] = mk(OP_STORE, 1'b1); lsu_val_cnt = 0;
    step();
    lsu_ready = 1'b0;
    repeat (5) begin refill(4'b0000, OP_LOAD); lsu_prep(100, 0); step(); end
    lsu_ready = 1'b1; step();
    lsu_ready = 1'b0;
    repeat (4) begin refill(4'b0000, OP_LOAD); lsu_prep(100, 0); step(); end
    chk("lsu_val_cycles", 64'(lsu_val_cnt), 64'd6);

    // Response presented while the requester is not ready for three cycles.
    do_reset();
    lsu_ready = 1'b1; rsp_rdy = '0; req_header[0] = mk(OP_LOAD, 1'b1);
    rsp_cnt[0] = 0; lrr_cnt = 0;
    step();
    refill(4'b0000, OP_LOAD); step();
    repeat (3) begin lsu_prep(100, 0); step(); end
    rsp_rdy[0] = 1'b1; lsu_prep(100, 0); step();
    repeat (2) begin lsu_prep(100, 0); step(); end
    chk("rsp_hold_cycles", 64'(rsp_cnt[0]), 64'd4);
    chk("rsp_rdy_cycles", 64'(lrr_cnt), 64'd1);

    // Reset in the middle of a locked owner's transaction.
    do_reset();
    lsu_ready = 1'b1; rsp_rdy = '1;
    req_header[1] = mk(OP_LOCK, 1'b1);
    for (int n = 0; n < 20 && !m_held; n++) begin refill(4'b0000, OP_LOAD); lsu_prep(100, 0); step(); end
    req_header[1] = mk(OP_LOAD, 1'b1);
    for (int n = 0; n < 20 && m_phase != 2; n++) begin refill(4'b0000, OP_LOAD); lsu_prep(0, 0); step(); end
    chk("pre_rst_lock", 64'(lock_held), 64'd1);
    rst = 1'b1; req_header[0] = mk(OP_LOAD, 1'b1); lsu_rsp.val = 1'b1;
    refill(4'b0000, OP_LOAD);
    step(); step();
    rst = 1'b0; clear_obs(); rel = scyc + 1;
    repeat (4) begin refill(4'b0000, OP_LOAD); lsu_prep(100, 0); step(); end
    chk("post_rst_lock", 64'(lock_held), 64'd0);
    chk("post_rst_grant", 64'(obs_g.size() > 0 ? obs_g[0] : -1), 64'd0);
    chk("post_rst_latency", 64'(obs_t.size() > 0 ? obs_t[0] : -1), 64'(rel));

    // Only requester 3 active: wrap search re-grants it every three cycles.
    do_reset();
    lsu_ready = 1'b1; rsp_rdy = '1; clear_obs();
    repeat (12) begin refill(4'b1000, OP_LOAD); lsu_prep(100, 0); step(); end
    chk("wrap_count", 64'(obs_g.size()), 64'd4);
    for (int k = 0; k < obs_g.size() && k < 4; k++) chk("wrap_idx", 64'(obs_g[k]), 64'd3);
    for (int k = 1; k < obs_t.size() && k < 4; k++) chk("wrap_spacing", 64'(obs_t[k] - obs_t[k-1]), 64'd3);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_header[i].val) begin
          acc[i] = 1'b0;
          req_header[i] = mk(rand_op(), ($urandom % 2) == 1);
        end
      end
      lsu_ready = ($urandom % 100) < 70;
      rsp_rdy   = 4'($urandom);
      lsu_prep(60, 1);
      step();
    end
    repeat (2) step();
    chk("q_grant_drained", 64'(q_grant.size()), 64'd0);
    chk("q_lsu_drained", 64'(q_lsu.size()), 64'd0);
    chk("q_rsp_drained", 64'(q_rsp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/falafel_lsu_arbiter.md
FALAFEL_LSU_ARBITER -- requirements
Module: falafel_lsu_arbiter

Interface
REQ-001 Parameter: N_REQ, default 2, number of requesters sharing one falafel LSU; legal range 2..8.
REQ-002 Parameter: IDX_W, default $clog2(N_REQ), requester index width.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 req_header_i  input  N_REQ x header_req_t  per-requester request; the .val field marks it valid.
REQ-007 req_rdy_o  output  N_REQ  per-requester accept strobe.
REQ-008 rsp_header_o  output  N_REQ x header_rsp_t  per-requester response; the .val field marks it valid.
REQ-009 rsp_rdy_i  input  N_REQ  per-requester response ready.
REQ-010 lsu_req_header_o  output  header_req_t  request to the LSU core side.
REQ-011 lsu_ready_i  input  1  LSU ready (the LSU's lsu_ready_o).
REQ-012 lsu_rsp_header_i  input  header_rsp_t  response from the LSU.
REQ-013 lsu_rsp_rdy_o  output  1  response ready to the LSU (the LSU's core_rdy_i).
REQ-014 lock_held_o  output  1  high while a requester owns the memory lock.
REQ-015 lock_owner_o  output  IDX_W  index of the lock owner; 0 when lock_held_o is 0.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT_RSP.
REQ-017 IDLE, eligibility: requester i is eligible iff req_header_i[i].val=1 and (lock_held=0 or i=lock_owner).
REQ-018 IDLE, selection: round-robin; the first eligible index searched from (last_grant+1) mod N_REQ upward with wrap.
REQ-019 IDLE, on a winner: assert req_rdy_o[winner]=1 for exactly that cycle, capture its header and index, go to ISSUE.
REQ-020 IDLE, no eligible requester: stay in IDLE, all req_rdy_o=0.
REQ-021 req_rdy_o is asserted only in IDLE and only for the winner; at most one bit is high in any cycle.
REQ-022 ISSUE: lsu_req_header_o = captured header with .val=1; on lsu_ready_i=1 go to WAIT_RSP; otherwise hold the header unchanged.
REQ-023 lsu_req_header_o.val SHALL be 0 in every state other than ISSUE, so the LSU sees exactly one valid cycle per request when it is ready.
REQ-024 WAIT_RSP, routing:
  - rsp_header_o[grant] = lsu_rsp_header_i, combinational.
  - lsu_rsp_rdy_o = rsp_rdy_i[grant].
  - every other rsp_header_o.val = 0.
REQ-025 WAIT_RSP, handshake: on lsu_rsp_header_i.val=1 and rsp_rdy_i[grant]=1, set last_grant=grant and go to IDLE.
REQ-026 WAIT_RSP, lock update, in the same handshake cycle:
  - captured op LOCK: lock_held=1, lock_owner=grant.
  - captured op UNLOCK: lock_held=0, lock_owner=0.
  - all other ops: lock state unchanged.
REQ-027 UNLOCK while lock_held=0 is forwarded normally and leaves lock_held=0.
REQ-028 Requests from non-owners while locked stay pending; their .val stays high until accepted, and no timeout applies.
REQ-029 Minimum request-to-response latency is 3 cycles of arbiter overhead (IDLE accept, ISSUE, WAIT_RSP) plus the LSU latency; back-to-back grants are allowed (IDLE on the cycle after the handshake).
REQ-030 Requester changes to req_header_i after acceptance have no effect on the in-flight request.
REQ-031 Outside WAIT_RSP: all rsp_header_o.val=0 and lsu_rsp_rdy_o=0.

Reset
REQ-032 On rst_i=1 at a clock edge:
  - state=IDLE, last_grant=N_REQ-1 (first grant search starts at 0), grant=0.
  - captured header and lock_held cleared; lock_owner=0.
REQ-033 While in or leaving reset, outputs are: req_rdy_o=0, lsu_req_header_o.val=0, all rsp_header_o.val=0, lsu_rsp_rdy_o=0, lock_held_o=0, lock_owner_o=0.
REQ-034 Reset mid-transaction abandons the in-flight request; the arbiter re-arbitrates from IDLE with no response issued to the old requester.

Verification
REQ-035 Requesters 0 and 1 both assert LOAD continuously, LSU ready, rsp_rdy all 1 -> grant order 0,1,0,1, each req_rdy_o a 1-cycle pulse.
REQ-036 Requester 1 sends LOCK; then 0 and 1 both request LOAD -> lock_held_o=1, lock_owner_o=1, only 1 is granted until 1 sends UNLOCK; the next grant goes to 0.
REQ-037 lsu_ready_i held 0 for 5 cycles in ISSUE -> lsu_req_header_o held stable with .val=1 for 5 cycles, then 1 cycle with lsu_ready_i=1, then .val=0.
REQ-038 LSU response valid while rsp_rdy_i[grant]=0 for 3 cycles -> lsu_rsp_rdy_o=0, FSM stays in WAIT_RSP; the handshake completes on the cycle rsp_rdy_i rises.
REQ-039 rst_i pulsed during WAIT_RSP after a LOCK -> lock_held_o=0; a new request from requester 0 is granted 1 cycle after reset deasserts.
REQ-040 N_REQ=4 with only requester 3 active after a grant to 3 -> 3 is re-granted (wrap search), no idle gap beyond REQ-029.
